// File: rtl/can_tx_scheduler_if.sv
// Engine-side handshake between the scheduler and the byte-serial CAN transmit engine.
// Ports: eng_data (byte to engine), eng_tx_req (one-cycle pulse), eng_tx_done (level from engine).
interface can_tx_scheduler_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] eng_data;
    logic              eng_tx_req;
    logic              eng_tx_done;

    modport master (
        output eng_data,
        output eng_tx_req,
        input  eng_tx_done
    );

    modport slave (
        input  eng_data,
        input  eng_tx_req,
        output eng_tx_done
    );
endinterface

// File: rtl/can_tx_scheduler.sv
// Shares one byte-serial CAN transmit engine between NUM_REQ requesters.
// Ports: clk, reset (sync, active-high); req/req_data from requesters; ack/err one-cycle
// pulses per requester; grant_id, busy; timeout_flag (sticky) with err_clr; eng = engine
// handshake (master). Optional macro CAN_SCHED_ROUND_ROBIN_EN selects round-robin
// arbitration instead of fixed lowest-index priority.
module can_tx_scheduler #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 8,
    parameter int TIMEOUT_CYC = 64,
    localparam int IDX_W      = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        ack,
    output logic [NUM_REQ-1:0]        err,
    output logic [IDX_W-1:0]          grant_id,
    output logic                      busy,
    output logic                      timeout_flag,
    input  logic                      err_clr,
    can_tx_scheduler_if.master        eng
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_ACK,
        S_ERR
    } state_t;

    state_t              state_q;
    logic [NUM_REQ-1:0]  ack_q;
    logic [NUM_REQ-1:0]  err_q;
    logic [IDX_W-1:0]    grant_id_q;
    logic                busy_q;
    logic [DATA_W-1:0]   eng_data_q;
    logic                eng_tx_req_q;
    logic                tflag_q;
    logic                done_q;
    logic [15:0]         tmo_cnt_q;
    logic                done_rise;
    logic [IDX_W-1:0]    win;

    // Only a fresh rising edge of tx_done counts; a level left over from
    // the previous transfer is already captured in done_q.
    assign done_rise = eng.eng_tx_done & ~done_q;

`ifdef CAN_SCHED_ROUND_ROBIN_EN
    logic [IDX_W-1:0] rr_ptr_q;
    logic [IDX_W:0]   idx;

    // Walk downward so the closest set bit at/after rr_ptr is written last.
    always_comb begin
        win = '0;
        idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
            if (idx >= (IDX_W+1)'(NUM_REQ)) begin
                idx = idx - (IDX_W+1)'(NUM_REQ);
            end
            if (req[idx[IDX_W-1:0]]) begin
                win = idx[IDX_W-1:0];
            end
        end
    end
`else
    always_comb begin
        win = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[IDX_W'(k)]) begin
                win = IDX_W'(k);
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            ack_q        <= '0;
            err_q        <= '0;
            grant_id_q   <= '0;
            busy_q       <= 1'b0;
            eng_data_q   <= '0;
            eng_tx_req_q <= 1'b0;
            tflag_q      <= 1'b0;
            done_q       <= 1'b0;
            tmo_cnt_q    <= '0;
`ifdef CAN_SCHED_ROUND_ROBIN_EN
            rr_ptr_q     <= '0;
`endif
        end else begin
            done_q <= eng.eng_tx_done;
            // A set in the ERR transition below overrides this clear.
            if (err_clr) begin
                tflag_q <= 1'b0;
            end
            unique case (state_q)
                S_IDLE: begin
                    if (|req) begin
                        grant_id_q   <= win;
                        eng_data_q   <= req_data[int'(win)*DATA_W +: DATA_W];
                        busy_q       <= 1'b1;
                        eng_tx_req_q <= 1'b1;
                        state_q      <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    eng_tx_req_q <= 1'b0;
                    tmo_cnt_q    <= '0;
                    state_q      <= S_WAIT;
                end
                S_WAIT: begin
                    if (done_rise) begin
                        ack_q   <= NUM_REQ'(1) << grant_id_q;
                        state_q <= S_ACK;
                    end else if (tmo_cnt_q == 16'(TIMEOUT_CYC - 1)) begin
                        err_q   <= NUM_REQ'(1) << grant_id_q;
                        tflag_q <= 1'b1;
                        state_q <= S_ERR;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 16'd1;
                    end
                end
                S_ACK, S_ERR: begin
                    ack_q   <= '0;
                    err_q   <= '0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
`ifdef CAN_SCHED_ROUND_ROBIN_EN
                    rr_ptr_q <= (grant_id_q == IDX_W'(NUM_REQ - 1)) ?
                                '0 : grant_id_q + 1'b1;
`endif
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ack            = ack_q;
    assign err            = err_q;
    assign grant_id       = grant_id_q;
    assign busy           = busy_q;
    assign timeout_flag   = tflag_q;
    assign eng.eng_data   = eng_data_q;
    assign eng.eng_tx_req = eng_tx_req_q;
endmodule

// File: tb/tb_can_tx_scheduler.sv
// Self-checking bench for can_tx_scheduler: directed scenarios plus randomized
// transfers compared against a transfer-level reference model.
module tb_can_tx_scheduler;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int T  = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    ack;
    logic [N-1:0]    err;
    logic [1:0]      grant_id;
    logic            busy;
    logic            timeout_flag;
    logic            err_clr;

    int checks = 0;
    int errors = 0;
    bit exp_flag = 1'b0;
    int rr = 0;

    can_tx_scheduler_if #(.DATA_W(DW)) eng_if ();

    can_tx_scheduler #(
        .NUM_REQ(N),
        .DATA_W(DW),
        .TIMEOUT_CYC(T)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req(req),
        .req_data(req_data),
        .ack(ack),
        .err(err),
        .grant_id(grant_id),
        .busy(busy),
        .timeout_flag(timeout_flag),
        .err_clr(err_clr),
        .eng(eng_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Winner from the arbitration rule applied to the requests IDLE sees.
    function automatic int pick(input logic [N-1:0] r);
        int i;
        for (int k = 0; k < N; k++) begin
`ifdef CAN_SCHED_ROUND_ROBIN_EN
            i = (rr + k) % N;
`else
            i = k;
`endif
            if (r[i[1:0]]) return i;
        end
        return 0;
    endfunction

    // One clock; the sticky flag model is advanced with the inputs seen at the edge.
    task automatic step(input bit set_flag);
        bit clr;
        bit rst;
        clr = err_clr;
        rst = reset;
        @(posedge clk);
        #1;
        if (rst) exp_flag = 1'b0;
        else if (set_flag) exp_flag = 1'b1;
        else if (clr) exp_flag = 1'b0;
        chk("timeout_flag", 32'(timeout_flag), 32'(exp_flag));
    endtask

    // One whole transfer starting with the scheduler in IDLE.
    // hi_at: WAIT step at which the engine raises done (0 = never).
    // lo_at: step at which a stale done drops (0 = right after the launch).
    task automatic xfer(input string tag, input int hi_at, input int lo_at,
                        input logic [N-1:0] next_req);
        int w;
        int oc;
        bit is_ack;
        logic [DW-1:0] b;
        logic [N-1:0] oh;
        w = pick(req);
        b = req_data[w*DW +: DW];
        oh = N'(1) << w;
        is_ack = (hi_at > 0) && (hi_at <= T);
        oc = is_ack ? hi_at : T;
        step(1'b0);
        chk({tag, ".tx_req"}, 32'(eng_if.eng_tx_req), 32'd1);
        chk({tag, ".grant"}, 32'(grant_id), 32'(w));
        chk({tag, ".data"}, 32'(eng_if.eng_data), 32'(b));
        chk({tag, ".busy"}, 32'(busy), 32'd1);
        if (lo_at == 0) eng_if.eng_tx_done = 1'b0;
        req = N'($urandom);
        req_data = $urandom;
        for (int k = 1; k <= oc; k++) begin
            step(1'b0);
            chk({tag, ".wait_quiet"}, {eng_if.eng_tx_req, ack, err},
                32'd0);
            chk({tag, ".hold"}, {busy, grant_id, eng_if.eng_data},
                {1'b1, 2'(w), b});
            if (k == lo_at) eng_if.eng_tx_done = 1'b0;
            if (k == hi_at) eng_if.eng_tx_done = 1'b1;
        end
        step(!is_ack);
        chk({tag, ".ack"}, 32'(ack), is_ack ? 32'(oh) : 32'd0);
        chk({tag, ".err"}, 32'(err), is_ack ? 32'd0 : 32'(oh));
        chk({tag, ".busy_end"}, 32'(busy), 32'd1);
        req = next_req;
`ifdef CAN_SCHED_ROUND_ROBIN_EN
        rr = (w + 1) % N;
`endif
        step(1'b0);
        chk({tag, ".idle"}, {busy, ack, err, eng_if.eng_tx_req}, 32'd0);
    endtask

    initial begin
        logic [N-1:0] nr;
        int hi;
        reset = 1'b1;
        req = '0;
        req_data = '0;
        err_clr = 1'b0;
        eng_if.eng_tx_done = 1'b0;
        step(1'b0);
        step(1'b0);
        chk("rst.ack_err", {ack, err}, 32'd0);
        chk("rst.grant", 32'(grant_id), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.eng", {eng_if.eng_tx_req, eng_if.eng_data}, 32'd0);
        reset = 1'b0;
        step(1'b0);
        chk("idle.noreq", {busy, eng_if.eng_tx_req}, 32'd0);

        // Single transfer from requester 2.
        req = 4'b0100;
        req_data = 32'h5EA5_C3D2;
        xfer("single", 10, 0, 4'b0000);
        step(1'b0);
        chk("single.after", {busy, eng_if.eng_tx_req, ack}, 32'd0);

        // Priority order with requesters dropping after service.
        req = 4'b1011;
        req_data = 32'h4433_2211;
        xfer("prio0", 5, 0, 4'b1010);
        req_data = 32'h4433_2211;
        xfer("prio1", 3, 0, 4'b1000);
        req_data = 32'h4433_2211;
        xfer("prio3", 7, 0, 4'b0000);

        // Two requesters held continuously.
        req = 4'b0011;
        for (int i = 0; i < 4; i++) begin
            req_data = $urandom;
            xfer("hold2", 2 + i, 0, i == 3 ? 4'b0000 : 4'b0011);
        end

        // Timeout: engine never answers; flag sticks.
        req = 4'b1000;
        xfer("timeout", 0, 0, 4'b0000);
        for (int i = 0; i < 3; i++) step(1'b0);

        // Reset in the middle of WAIT_DONE.
        req = 4'b0010;
        req_data = $urandom;
        step(1'b0);
        chk("rstmid.launch", 32'(eng_if.eng_tx_req), 32'd1);
        for (int i = 0; i < 5; i++) step(1'b0);
        reset = 1'b1;
        step(1'b0);
        rr = 0;
        chk("rstmid.ack_err", {ack, err}, 32'd0);
        chk("rstmid.out", {busy, grant_id, eng_if.eng_tx_req,
            eng_if.eng_data}, 32'd0);
        step(1'b0);
        chk("rstmid.hold", {busy, ack, err, eng_if.eng_tx_req}, 32'd0);
        reset = 1'b0;
        xfer("rstmid.regrant", 3, 0, 4'b0001);

        // Stale done high through launch; only the later rise counts.
        req_data = $urandom;
        xfer("stale", 8, 3, 4'b0100);

        // Done rising at the last possible WAIT cycle still wins.
        req_data = $urandom;
        xfer("edge_ack", T, 0, 4'b0010);

        // Timeout with err_clr held: the set wins, then the clear.
        err_clr = 1'b1;
        xfer("tmo_clr", 0, 0, 4'b0000);
        step(1'b0);
        err_clr = 1'b0;

        // Plain err_clr pulse after a timeout.
        req = 4'b0001;
        xfer("tmo2", 0, 0, 4'b0000);
        step(1'b0);
        err_clr = 1'b1;
        step(1'b0);
        err_clr = 1'b0;
        step(1'b0);

        // Randomized transfers.
        nr = '0;
        while (nr == '0) nr = N'($urandom);
        req = nr;
        for (int i = 0; i < 40; i++) begin
            req_data = $urandom;
            hi = $urandom_range(0, T);
            nr = '0;
            while (nr == '0) nr = N'($urandom);
            if (i == 39) nr = '0;
            if ($urandom_range(0, 5) == 0) err_clr = 1'b1;
            else err_clr = 1'b0;
            xfer("rand", hi, 0, nr);
        end
        err_clr = 1'b0;
        step(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/can_tx_scheduler.md
Name: can_tx_scheduler

Overview:
- Shares one byte-serial CAN transmit engine between NUM_REQ requesters.
- Arbitrates pending requests and latches the winner's byte.
- Drives the engine's tx_req/data_in handshake, waits for tx_done, then returns a per-requester ack, or an error on timeout.
- Sits between the message sources and the CAN transmit engine in the controller subsystem.

Parameters:
- NUM_REQ, 4, number of requesters (2..16); IDX_W = max(1, clog2(NUM_REQ)).
- DATA_W, 8, byte width; matches the engine's data_in.
- TIMEOUT_CYC, 64, maximum cycles in WAIT_DONE before declaring an error (2..65535).

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- req  input  NUM_REQ  per-requester transmit request (level)
- req_data  input  NUM_REQ*DATA_W  requester i byte at [i*DATA_W +: DATA_W]
- ack  output  NUM_REQ  one-cycle pulse: requester's byte transmitted
- err  output  NUM_REQ  one-cycle pulse: requester's transfer timed out
- grant_id  output  IDX_W  index of requester currently being served
- busy  output  1  high in any state except IDLE
- eng_data  output  DATA_W  byte to engine data_in
- eng_tx_req  output  1  engine tx_req, one-cycle pulse
- eng_tx_done  input  1  engine tx_done (level; stays high until next accepted request)
- timeout_flag  output  1  sticky timeout indicator
- err_clr  input  1  clears timeout_flag

Behaviour:
- Clock/reset: one clock clk; reset is synchronous and active-high.
- All outputs are registered.
- Reset values: state=IDLE; ack=0, err=0, grant_id=0, busy=0, eng_data=0, eng_tx_req=0, timeout_flag=0; rr_ptr=0, done_q=0, tmo_cnt=0.
- Reset asserted in any state forces these values at the next edge. An in-flight transfer is abandoned, with no ack or err.
- done_q registers eng_tx_done every cycle; done_rise = eng_tx_done & ~done_q.
- A stale high tx_done from a previous transfer is never accepted. Only a rising edge that occurs after LAUNCH counts.
- IDLE:
  - If req != 0, select the winner (fixed priority: lowest index).
  - Register grant_id=winner, eng_data=req_data[winner], busy=1.
  - Go to LAUNCH. Otherwise remain in IDLE.
- LAUNCH: eng_tx_req=1 for exactly this one cycle; clear tmo_cnt; go to WAIT_DONE.
- WAIT_DONE:
  - done_rise → ACK.
  - Else if tmo_cnt == TIMEOUT_CYC-1 → ERR.
  - Else tmo_cnt+1. tmo_cnt is 16 bits and never wraps.
- ACK: ack[grant_id]=1 for one cycle; go to IDLE with busy=0.
- ERR: err[grant_id]=1 for one cycle; timeout_flag=1; go to IDLE with busy=0.
- Latency: req seen in IDLE at cycle N → eng_tx_req high at cycle N+1. done_rise at cycle M → ack at cycle M+1.
- Back-to-back transfers: minimum 4 cycles of scheduler overhead per byte plus engine time.
- eng_data and grant_id hold steady from IDLE exit until the next grant.
- A requester dropping req mid-transfer is ignored; the transfer completes and ack/err is still issued.
- A requester whose req is still high after its ack is re-arbitrated normally in the next IDLE.
- req_data is sampled only in IDLE; later changes do not affect the byte in flight.
- timeout_flag: set has priority over err_clr when both occur in the same cycle. Otherwise err_clr clears it at the next edge.
- At most one bit of ack|err is high in any cycle. ack and err are never high together.

Optional Feature:
- Macro: CAN_SCHED_ROUND_ROBIN_EN.
- Defined:
  - Round-robin arbitration. The winner is the first set req bit at or after rr_ptr, searching upward with wrap.
  - In ACK and ERR, rr_ptr=grant_id+1, wrapping NUM_REQ-1 → 0.
- Undefined: fixed priority, lowest index wins; the rr_ptr logic is not built.

Test Plan:
- Single transfer: req=0b0100, req_data[2]=0xA5; engine model raises done 10 cycles after the pulse.
  Expected: eng_tx_req is a single pulse one cycle after IDLE sees req; eng_data=0xA5; grant_id=2; ack=0b0100 for one cycle; busy falls with the return to IDLE.
- Fixed priority: req=0b1011 held, each requester dropping its req after its own ack.
  Expected: service order 0, 1, 3; exactly three ack pulses.
- CAN_SCHED_ROUND_ROBIN_EN defined, req=0b0011 held continuously for 4 transfers.
  Expected: grants 0, 1, 0, 1.
- Timeout: TIMEOUT_CYC=16, engine never raises done.
  Expected: err[grant_id] pulses 16 cycles after entering WAIT_DONE; timeout_flag=1 and holds until err_clr; no ack.
- Stale done: eng_tx_done held high through LAUNCH and 3 WAIT cycles, then low 5 cycles, then high.
  Expected: ack only after the second rise; no early ack.
- Reset at WAIT_DONE cycle 5.
  Expected: after the edge, all outputs 0 and state IDLE; no ack/err; with req still pending, a new grant follows after reset deasserts.
